multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the RV32 subset datapath (yIF/yID/yEX/yDM/yWB/yPC). Steps each

---
 rtl/multicycle_ctrl.sv | 279 +++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the RV32 subset datapath: steps FETCH/DECODE/EXEC/MEM/WB,
// handshakes with shared memory and traps on illegal opcodes or memory timeouts.
module multicycle_ctrl #(
   parameter int BOOT_CYCLES = 1,
   parameter int TIMEOUT     = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       mem_ready,
   output logic       ir_we,
   output logic       pc_we,
   output logic       INT,
   output logic       isbranch,
   output logic       isjump,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       ALUSrc,
   output logic       Mem2Reg,
   output logic       link_sel,
   output logic [2:0] alu_op,
   output logic [2:0] state,
   output logic       illegal,
   output logic       mem_timeout
);

   typedef enum logic [2:0] {
      S_BOOT   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6,
      S_UNUSED = 3'd7
   } state_e;

   typedef enum logic [2:0] {
      C_R   = 3'd0,
      C_I   = 3'd1,
      C_LW  = 3'd2,
      C_SW  = 3'd3,
      C_BEQ = 3'd4,
      C_JAL = 3'd5
   } class_e;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

   // Returns {legal, alu_op} for the shared R/I funct3 decode.
   function automatic logic [3:0] f3_alu(input logic [2:0] f3, input logic sub);
      case (f3)
         3'b000:  f3_alu = {1'b1, (sub ? ALU_SUB : ALU_ADD)};
         3'b111:  f3_alu = {1'b1, ALU_AND};
         3'b110:  f3_alu = {1'b1, ALU_OR};
         3'b010:  f3_alu = {1'b1, ALU_SLT};
         default: f3_alu = {1'b0, ALU_ADD};
      endcase
   endfunction

   state_e          state_q, state_d;
   logic [BW-1:0]   boot_q, boot_d;
   logic [TW-1:0]   cnt_q, cnt_d;
   logic            illegal_q, illegal_d;
   logic            mem_timeout_q, mem_timeout_d;
   class_e          class_q;
   logic [2:0]      alu_q;

   logic            dec_legal;
   class_e          dec_class;
   logic [2:0]      dec_alu;
   logic [3:0]      rr_res;
   logic [3:0]      ri_res;
   logic            tmo_hit;
   logic            src_sel;

   logic ir_we_c, pc_we_c, int_c, isbranch_c, isjump_c, mem_read_c, mem_write_c;
   logic reg_write_c, alu_src_c, mem2reg_c, link_sel_c;
   logic [2:0] alu_op_c;

   always_comb begin
      dec_legal = 1'b0;
      dec_class = C_R;
      dec_alu   = ALU_ADD;
      rr_res    = f3_alu(funct3, funct7b5);
      ri_res    = f3_alu(funct3, 1'b0);
      case (opcode)
         OP_R: begin
            dec_class = C_R;
            dec_legal = rr_res[3];
            dec_alu   = rr_res[2:0];
         end
         OP_I: begin
            dec_class = C_I;
            dec_legal = ri_res[3];
            dec_alu   = ri_res[2:0];
         end
         OP_LW: begin
            dec_class = C_LW;
            dec_legal = (funct3 == 3'b010);
         end
         OP_SW: begin
            dec_class = C_SW;
            dec_legal = (funct3 == 3'b010);
         end
         OP_BEQ: begin
            dec_class = C_BEQ;
            dec_alu   = ALU_SUB;
            dec_legal = (funct3 == 3'b000);
         end
         OP_JAL: begin
            dec_class = C_JAL;
            dec_legal = 1'b1;
         end
         default: ;
      endcase
   end

   // Class and ALU op are captured once in DECODE so EXEC..WB controls stay glitch-free.
   always_ff @(posedge clk) begin
      if (state_q == S_DECODE) begin
         class_q <= dec_class;
         alu_q   <= dec_alu;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_BOOT;
         boot_q        <= '0;
         cnt_q         <= '0;
         illegal_q     <= 1'b0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         boot_q        <= boot_d;
         cnt_q         <= cnt_d;
         illegal_q     <= illegal_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   assign tmo_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);
   assign src_sel = (class_q == C_I) || (class_q == C_LW) || (class_q == C_SW);

   always_comb begin
      state_d       = state_q;
      boot_d        = '0;
      cnt_d         = '0;
      illegal_d     = illegal_q;
      mem_timeout_d = mem_timeout_q;
      ir_we_c       = 1'b0;
      pc_we_c       = 1'b0;
      int_c         = 1'b0;
      isbranch_c    = 1'b0;
      isjump_c      = 1'b0;
      mem_read_c    = 1'b0;
      mem_write_c   = 1'b0;
      reg_write_c   = 1'b0;
      alu_src_c     = 1'b0;
      mem2reg_c     = 1'b0;
      link_sel_c    = 1'b0;
      alu_op_c      = 3'b000;
      if ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) begin
         alu_op_c  = alu_q;
         alu_src_c = src_sel;
      end
      case (state_q)
         S_BOOT: begin
            int_c   = 1'b1;
            pc_we_c = 1'b1;
            if (boot_q == BOOT_LAST) begin
               state_d = S_FETCH;
            end else begin
               boot_d = boot_q + BW'(1);
            end
         end
         S_FETCH: begin
            mem_read_c = 1'b1;
            if (mem_ready) begin
               ir_we_c = 1'b1;
               state_d = S_DECODE;
            end else if (tmo_hit) begin
               state_d       = S_TRAP;
               mem_timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         S_DECODE: begin
            if (dec_legal) begin
               state_d = S_EXEC;
            end else begin
               state_d   = S_TRAP;
               illegal_d = 1'b1;
            end
         end
         S_EXEC: begin
            case (class_q)
               C_R, C_I, C_JAL: state_d = S_WB;
               C_LW, C_SW:      state_d = S_MEM;
               C_BEQ: begin
                  isbranch_c = 1'b1;
                  pc_we_c    = 1'b1;
                  state_d    = S_FETCH;
               end
               default:         state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            mem_read_c  = (class_q == C_LW);
            mem_write_c = (class_q != C_LW);
            if (mem_ready) begin
               if (class_q == C_LW) begin
                  state_d = S_WB;
               end else begin
                  pc_we_c = 1'b1;
                  state_d = S_FETCH;
               end
            end else if (tmo_hit) begin
               state_d       = S_TRAP;
               mem_timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         S_WB: begin
            reg_write_c = 1'b1;
            pc_we_c     = 1'b1;
            mem2reg_c   = (class_q == C_LW);
            link_sel_c  = (class_q == C_JAL);
            isjump_c    = (class_q == C_JAL);
            state_d     = S_FETCH;
         end
         S_TRAP: begin
            int_c   = 1'b1;
            pc_we_c = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Reset forces every strobe low at once, abandoning any memory access in flight.
   assign ir_we       = rst_n & ir_we_c;
   assign pc_we       = rst_n & pc_we_c;
   assign INT         = rst_n & int_c;
   assign isbranch    = rst_n & isbranch_c;
   assign isjump      = rst_n & isjump_c;
   assign MemRead     = rst_n & mem_read_c;
   assign MemWrite    = rst_n & mem_write_c;
   assign RegWrite    = rst_n & reg_write_c;
   assign ALUSrc      = rst_n & alu_src_c;
   assign Mem2Reg     = rst_n & mem2reg_c;
   assign link_sel    = rst_n & link_sel_c;
   assign alu_op      = rst_n ? alu_op_c : 3'b000;
   assign state       = state_q;
   assign illegal     = illegal_q;
   assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a table of per-cycle vectors plus hand-written
// sequences for memory waits, timeouts and asynchronous reset mid-access.
module tb_multicycle_ctrl;

   localparam logic [2:0] SB = 3'd0, SF = 3'd1, SD = 3'd2, SE = 3'd3, SM = 3'd4, SW = 3'd5, ST = 3'd6;

   localparam logic [10:0] NONE = 11'h000;
   localparam logic [10:0] IRWE = 11'h400;
   localparam logic [10:0] PCWE = 11'h200;
   localparam logic [10:0] INTB = 11'h100;
   localparam logic [10:0] BR   = 11'h080;
   localparam logic [10:0] JMP  = 11'h040;
   localparam logic [10:0] MRD  = 11'h020;
   localparam logic [10:0] MWR  = 11'h010;
   localparam logic [10:0] RWR  = 11'h008;
   localparam logic [10:0] ASRC = 11'h004;
   localparam logic [10:0] M2R  = 11'h002;
   localparam logic [10:0] LNK  = 11'h001;

   localparam logic [31:0] I_ADD  = 32'h00208033;
   localparam logic [31:0] I_SUB  = 32'h40208033;
   localparam logic [31:0] I_ADDI = 32'h40008093;
   localparam logic [31:0] I_ORI  = 32'h0060E093;
   localparam logic [31:0] I_SLT  = 32'h0020A033;
   localparam logic [31:0] I_AND  = 32'h0020F033;
   localparam logic [31:0] I_LW   = 32'h0000A083;
   localparam logic [31:0] I_SW   = 32'h0010A023;
   localparam logic [31:0] I_BEQ  = 32'h00208063;
   localparam logic [31:0] I_JAL  = 32'h0000006F;
   localparam logic [31:0] I_BAD  = 32'h0000007F;
   localparam logic [31:0] I_LB   = 32'h00008083;

   typedef struct {
      string       name;
      logic        rst;
      logic [31:0] ins;
      logic        rdy;
      logic [2:0]  st;
      logic [10:0] ctl;
      logic [2:0]  alu;
      logic        care;
      logic        ill;
      logic        tmo;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] ins = 32'h0;
   logic        mem_ready = 1'b0;
   logic ir_we, pc_we, INT, isbranch, isjump, MemRead, MemWrite, RegWrite, ALUSrc, Mem2Reg, link_sel;
   logic [2:0] alu_op, state;
   logic illegal, mem_timeout;

   vec_t tbl[$];
   int   vectors = 0;
   int   miscompares = 0;
   logic ill_e = 1'b0;
   logic tmo_e = 1'b0;

   multicycle_ctrl #(.BOOT_CYCLES(1), .TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(ins[6:0]), .funct3(ins[14:12]), .funct7b5(ins[30]),
      .mem_ready(mem_ready), .ir_we(ir_we), .pc_we(pc_we), .INT(INT), .isbranch(isbranch),
      .isjump(isjump), .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
      .ALUSrc(ALUSrc), .Mem2Reg(Mem2Reg), .link_sel(link_sel), .alu_op(alu_op), .state(state),
      .illegal(illegal), .mem_timeout(mem_timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string n, input logic [2:0] st, input logic [10:0] ctl,
                        input logic [2:0] alu, input logic care, input logic ill, input logic tmo);
      logic [10:0] act;
      act = {ir_we, pc_we, INT, isbranch, isjump, MemRead, MemWrite, RegWrite, ALUSrc, Mem2Reg, link_sel};
      vectors++;
      if (state !== st || act !== ctl || (care && alu_op !== alu) || illegal !== ill || mem_timeout !== tmo) begin
         miscompares++;
         $display("FAIL %s: got state=%0d ctl=%b alu=%b ill=%b tmo=%b, expected state=%0d ctl=%b alu=%b ill=%b tmo=%b",
                  n, state, act, alu_op, illegal, mem_timeout, st, ctl, alu, ill, tmo);
      end
   endtask

   // Drive one cycle's inputs, compare at the falling edge, then advance past the rising edge.
   task automatic step(input string n, input logic [31:0] i, input logic rdy, input logic [2:0] st,
                       input logic [10:0] ctl, input logic [2:0] alu = 3'b000, input logic care = 1'b0);
      rst_n = 1'b1;
      ins = i;
      mem_ready = rdy;
      @(negedge clk);
      check(n, st, ctl, alu, care, ill_e, tmo_e);
      @(posedge clk);
      #1;
   endtask

   task automatic add(input string n, input logic [31:0] i, input logic rdy, input logic [2:0] st,
                      input logic [10:0] ctl, input logic [2:0] alu = 3'b000, input logic care = 1'b0);
      vec_t v;
      v.name = n; v.rst = 1'b1; v.ins = i; v.rdy = rdy; v.st = st; v.ctl = ctl;
      v.alu = alu; v.care = care; v.ill = ill_e; v.tmo = tmo_e;
      tbl.push_back(v);
   endtask

   task automatic add_fd(input string n, input logic [31:0] i);
      add({n, "_fetch"}, i, 1'b1, SF, IRWE | MRD);
      add({n, "_decode"}, i, 1'b1, SD, NONE);
   endtask

   task automatic add_alu(input string n, input logic [31:0] i, input logic [2:0] alu, input logic src);
      logic [10:0] s;
      s = src ? ASRC : NONE;
      add_fd(n, i);
      add({n, "_exec"}, i, 1'b1, SE, s, alu, 1'b1);
      add({n, "_wb"}, i, 1'b1, SW, RWR | PCWE | s, alu, 1'b1);
   endtask

   initial begin
      vec_t r;
      r.name = "reset"; r.rst = 1'b0; r.ins = I_ADD; r.rdy = 1'b1; r.st = SB; r.ctl = NONE;
      r.alu = 3'b000; r.care = 1'b1; r.ill = 1'b0; r.tmo = 1'b0;
      tbl.push_back(r);
      add("boot", I_ADD, 1'b0, SB, INTB | PCWE);
      add("add_fetch_wait", I_ADD, 1'b0, SF, MRD);
      add_alu("add", I_ADD, 3'b010, 1'b0);
      add_alu("sub", I_SUB, 3'b110, 1'b0);
      add_alu("addi_b30", I_ADDI, 3'b010, 1'b1);
      add_alu("ori", I_ORI, 3'b001, 1'b1);
      add_alu("slt", I_SLT, 3'b111, 1'b0);
      add_alu("and", I_AND, 3'b000, 1'b0);
      add_fd("lw", I_LW);
      add("lw_exec", I_LW, 1'b1, SE, ASRC, 3'b010, 1'b1);
      add("lw_mem", I_LW, 1'b1, SM, MRD | ASRC, 3'b010, 1'b1);
      add("lw_wb", I_LW, 1'b1, SW, RWR | PCWE | ASRC | M2R, 3'b010, 1'b1);
      add_fd("beq", I_BEQ);
      add("beq_exec", I_BEQ, 1'b1, SE, BR | PCWE, 3'b110, 1'b1);
      add_fd("jal", I_JAL);
      add("jal_exec", I_JAL, 1'b1, SE, NONE);
      add("jal_wb", I_JAL, 1'b1, SW, RWR | PCWE | JMP | LNK);
      add_fd("bad7f", I_BAD);
      ill_e = 1'b1;
      add("bad7f_trap", I_BAD, 1'b1, ST, INTB | PCWE);
      add_fd("lb", I_LB);
      add("lb_trap", I_LB, 1'b1, ST, INTB | PCWE);

      #1;
      foreach (tbl[k]) begin
         rst_n = tbl[k].rst;
         ins = tbl[k].ins;
         mem_ready = tbl[k].rdy;
         @(negedge clk);
         check(tbl[k].name, tbl[k].st, tbl[k].ctl, tbl[k].alu, tbl[k].care, tbl[k].ill, tbl[k].tmo);
         @(posedge clk);
         #1;
      end

      // SW with three stalled cycles: MemWrite held throughout, pc_we only on the ready cycle.
      step("sw_fetch", I_SW, 1'b1, SF, IRWE | MRD);
      step("sw_decode", I_SW, 1'b1, SD, NONE);
      step("sw_exec", I_SW, 1'b1, SE, ASRC, 3'b010, 1'b1);
      for (int w = 0; w < 3; w++) step("sw_mem_wait", I_SW, 1'b0, SM, MWR | ASRC, 3'b010, 1'b1);
      step("sw_mem_ready", I_SW, 1'b1, SM, MWR | ASRC | PCWE, 3'b010, 1'b1);

      // Fetch never answered: four wait cycles, then trap with the sticky timeout flag.
      for (int w = 0; w < 4; w++) step("fetch_tmo_wait", I_ADD, 1'b0, SF, MRD);
      tmo_e = 1'b1;
      step("fetch_tmo_trap", I_ADD, 1'b0, ST, INTB | PCWE);

      // Ready arriving on the fourth wait cycle still completes normally.
      for (int w = 0; w < 3; w++) step("fetch_late_wait", I_ADD, 1'b0, SF, MRD);
      step("fetch_late_ready", I_ADD, 1'b1, SF, IRWE | MRD);
      step("late_decode", I_ADD, 1'b1, SD, NONE);
      step("late_exec", I_ADD, 1'b1, SE, NONE, 3'b010, 1'b1);
      step("late_wb", I_ADD, 1'b1, SW, RWR | PCWE, 3'b010, 1'b1);

      // LW data phase never answered.
      step("lwto_fetch", I_LW, 1'b1, SF, IRWE | MRD);
      step("lwto_decode", I_LW, 1'b1, SD, NONE);
      step("lwto_exec", I_LW, 1'b1, SE, ASRC, 3'b010, 1'b1);
      for (int w = 0; w < 4; w++) step("lwto_mem_wait", I_LW, 1'b0, SM, MRD | ASRC, 3'b010, 1'b1);
      step("lwto_trap", I_LW, 1'b0, ST, INTB | PCWE);

      // Asynchronous reset in the middle of an LW memory access.
      step("rst_lw_fetch", I_LW, 1'b1, SF, IRWE | MRD);
      step("rst_lw_decode", I_LW, 1'b1, SD, NONE);
      step("rst_lw_exec", I_LW, 1'b1, SE, ASRC, 3'b010, 1'b1);
      mem_ready = 1'b0;
      @(negedge clk);
      check("rst_lw_mem", SM, MRD | ASRC, 3'b010, 1'b1, ill_e, tmo_e);
      #2;
      rst_n = 1'b0;
      #1;
      ill_e = 1'b0;
      tmo_e = 1'b0;
      check("rst_async_drop", SB, NONE, 3'b000, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      step("rst_boot", I_LW, 1'b0, SB, INTB | PCWE);
      step("rst_fetch", I_LW, 1'b0, SF, MRD);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
